// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter sharing one SDRAM controller access
// port between N_SRC requesters using the REQ/ACK access handshake.
// A granted access is committed and always runs to the controller's ACK.
// Optional feature: define SDRAM_ARB_LOCK_EN to let the granted source keep
// the grant for up to MAX_LOCK back-to-back accesses via SRC_LOCK_IN.

package SDRAM_PKG;

    typedef logic [15:0] data_t;

    typedef struct packed {
        logic [23:0] addr;
        data_t       wdata;
        logic [1:0]  be;
    } dram_access_t;

endpackage

module sdram_arbiter
    import SDRAM_PKG::*;
#(
    parameter int unsigned N_SRC    = 4,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic               CLK,
    input  logic               RESET_IN,
    input  logic [N_SRC-1:0]   SRC_WRITE_IN,
    input  dram_access_t       SRC_ACS_IN [N_SRC],
    input  logic [N_SRC-1:0]   SRC_REQ_IN,
    input  logic [N_SRC-1:0]   SRC_LOCK_IN,
    output logic [N_SRC-1:0]   SRC_ACK_OUT,
    output data_t              SRC_DATA_OUT,
    output logic               DST_WRITE_OUT,
    output dram_access_t       DST_ACS_OUT,
    output logic               DST_REQ_OUT,
    input  logic               DST_ACK_IN,
    input  data_t              DST_DATA_IN,
    output logic [N_SRC-1:0]   GRANT_OUT
);

    localparam int unsigned PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state_q;
    logic [N_SRC-1:0] grant_q;
    logic [PW-1:0]    gidx_q;
    logic [PW-1:0]    ptr_q;
    logic             dst_req_q;
    logic             dst_write_q;
    dram_access_t     dst_acs_q;

    logic             pick_valid;
    logic [PW-1:0]    pick_idx;
    logic [PW-1:0]    ptr_next;
    logic             lock_keep;

`ifdef SDRAM_ARB_LOCK_EN
    localparam int unsigned LW = $clog2(MAX_LOCK) + 1;

    logic [LW-1:0] lock_cnt_q;

    assign lock_keep = SRC_LOCK_IN[gidx_q] && SRC_REQ_IN[gidx_q] &&
                       (lock_cnt_q < LW'(MAX_LOCK - 1));
`else
    logic unused_lock;

    assign lock_keep   = 1'b0;
    assign unused_lock = ^{SRC_LOCK_IN, 32'(MAX_LOCK)};
`endif

    // Round-robin pick: first requesting source at or above the pointer, wrapping.
    always_comb begin
        logic [PW:0] j;
        j          = '0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            j = {1'b0, ptr_q} + (PW+1)'(i);
            if (j >= (PW+1)'(N_SRC)) begin
                j = j - (PW+1)'(N_SRC);
            end
            if (!pick_valid && SRC_REQ_IN[j[PW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = j[PW-1:0];
            end
        end
    end

    assign ptr_next = (gidx_q == PW'(N_SRC - 1)) ? '0 : gidx_q + 1'b1;

    // Grant FSM: latch the winner's access in IDLE, hold it until the controller ACKs.
    always_ff @(posedge CLK) begin
        if (RESET_IN) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            ptr_q       <= '0;
            dst_req_q   <= 1'b0;
            dst_write_q <= 1'b0;
            dst_acs_q   <= '0;
`ifdef SDRAM_ARB_LOCK_EN
            lock_cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q     <= BUSY;
                        gidx_q      <= pick_idx;
                        grant_q     <= N_SRC'(1) << pick_idx;
                        dst_req_q   <= 1'b1;
                        dst_write_q <= SRC_WRITE_IN[pick_idx];
                        dst_acs_q   <= SRC_ACS_IN[pick_idx];
                    end
                end
                BUSY: begin
                    if (DST_ACK_IN) begin
                        if (lock_keep) begin
                            // Locked continuation: next access follows with no idle cycle.
                            dst_write_q <= SRC_WRITE_IN[gidx_q];
                            dst_acs_q   <= SRC_ACS_IN[gidx_q];
`ifdef SDRAM_ARB_LOCK_EN
                            lock_cnt_q  <= lock_cnt_q + 1'b1;
`endif
                        end else begin
                            state_q   <= IDLE;
                            grant_q   <= '0;
                            dst_req_q <= 1'b0;
                            ptr_q     <= ptr_next;
`ifdef SDRAM_ARB_LOCK_EN
                            lock_cnt_q <= '0;
`endif
                        end
                    end
                end
            endcase
        end
    end

    assign SRC_ACK_OUT   = (state_q == BUSY && DST_ACK_IN) ? grant_q : '0;
    assign SRC_DATA_OUT  = DST_DATA_IN;
    assign DST_REQ_OUT   = dst_req_q;
    assign DST_WRITE_OUT = dst_write_q;
    assign DST_ACS_OUT   = dst_acs_q;
    assign GRANT_OUT     = grant_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed testbench for sdram_arbiter (N_SRC=4, MAX_LOCK=4).
// Lock expectations follow SDRAM_ARB_LOCK_EN when it is defined.

module tb_sdram_arbiter;
    import SDRAM_PKG::*;

    logic         CLK = 1'b0;
    logic         RESET_IN;
    logic [3:0]   SRC_WRITE_IN;
    dram_access_t SRC_ACS_IN [4];
    logic [3:0]   SRC_REQ_IN;
    logic [3:0]   SRC_LOCK_IN;
    logic [3:0]   SRC_ACK_OUT;
    data_t        SRC_DATA_OUT;
    logic         DST_WRITE_OUT;
    dram_access_t DST_ACS_OUT;
    logic         DST_REQ_OUT;
    logic         DST_ACK_IN;
    data_t        DST_DATA_IN;
    logic [3:0]   GRANT_OUT;

    int total = 0;
    int bad   = 0;

    sdram_arbiter #(.N_SRC(4), .MAX_LOCK(4)) dut (
        .CLK          (CLK),
        .RESET_IN     (RESET_IN),
        .SRC_WRITE_IN (SRC_WRITE_IN),
        .SRC_ACS_IN   (SRC_ACS_IN),
        .SRC_REQ_IN   (SRC_REQ_IN),
        .SRC_LOCK_IN  (SRC_LOCK_IN),
        .SRC_ACK_OUT  (SRC_ACK_OUT),
        .SRC_DATA_OUT (SRC_DATA_OUT),
        .DST_WRITE_OUT(DST_WRITE_OUT),
        .DST_ACS_OUT  (DST_ACS_OUT),
        .DST_REQ_OUT  (DST_REQ_OUT),
        .DST_ACK_IN   (DST_ACK_IN),
        .DST_DATA_IN  (DST_DATA_IN),
        .GRANT_OUT    (GRANT_OUT)
    );

    always #5 CLK = ~CLK;

    // Distinct access descriptor per tag value.
    function automatic dram_access_t mk(input int v);
        dram_access_t a;
        a.addr  = 24'(v * 16 + 1);
        a.wdata = 16'(v) ^ 16'h5a5a;
        a.be    = 2'b11;
        return a;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        SRC_WRITE_IN = '0;
        SRC_REQ_IN   = '0;
        SRC_LOCK_IN  = '0;
        DST_ACK_IN   = 1'b0;
        DST_DATA_IN  = 16'hbeef;
        for (int i = 0; i < 4; i++) SRC_ACS_IN[i] = '0;
    endtask

    task automatic do_reset();
        RESET_IN = 1'b1;
        clear_inputs();
        step();
        step();
        RESET_IN = 1'b0;
    endtask

    task automatic test_reset();
        RESET_IN = 1'b1;
        clear_inputs();
        SRC_REQ_IN = 4'b1111;
        step();
        step();
        #1;
        total++;
        if ({DST_REQ_OUT, DST_WRITE_OUT, GRANT_OUT, SRC_ACK_OUT} !== 10'b0) begin
            bad++;
            $display("FAIL reset_ctl got req=%b wr=%b grant=%b ack=%b exp all 0",
                     DST_REQ_OUT, DST_WRITE_OUT, GRANT_OUT, SRC_ACK_OUT);
        end
        total++;
        if (DST_ACS_OUT !== '0) begin
            bad++;
            $display("FAIL reset_acs got=%h exp=0", DST_ACS_OUT);
        end
        RESET_IN = 1'b0;
        SRC_REQ_IN = '0;
    endtask

    task automatic test_single();
        do_reset();
        SRC_ACS_IN[1]   = mk(1);
        SRC_WRITE_IN[1] = 1'b1;
        SRC_REQ_IN[1]   = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 4) begin
                DST_ACK_IN    = 1'b1;
                SRC_REQ_IN[1] = 1'b0;
            end
            #1;
            total++;
            if (DST_REQ_OUT !== 1'b1 || GRANT_OUT !== 4'b0010 || DST_WRITE_OUT !== 1'b1) begin
                bad++;
                $display("FAIL single_busy c=%0d got req=%b grant=%b wr=%b exp 1 0010 1",
                         c, DST_REQ_OUT, GRANT_OUT, DST_WRITE_OUT);
            end
            total++;
            if (DST_ACS_OUT !== mk(1)) begin
                bad++;
                $display("FAIL single_acs c=%0d got=%h exp=%h", c, DST_ACS_OUT, mk(1));
            end
            total++;
            if (SRC_ACK_OUT !== ((c == 4) ? 4'b0010 : 4'b0000)) begin
                bad++;
                $display("FAIL single_ack c=%0d got=%b", c, SRC_ACK_OUT);
            end
            if (c == 4) begin
                total++;
                if (SRC_DATA_OUT !== 16'hbeef) begin
                    bad++;
                    $display("FAIL single_data got=%h exp=beef", SRC_DATA_OUT);
                end
            end
        end
        step();
        DST_ACK_IN = 1'b0;
        #1;
        total++;
        if (DST_REQ_OUT !== 1'b0 || GRANT_OUT !== 4'b0000 || SRC_ACK_OUT !== 4'b0000) begin
            bad++;
            $display("FAIL single_idle got req=%b grant=%b ack=%b exp 0 0000 0000",
                     DST_REQ_OUT, GRANT_OUT, SRC_ACK_OUT);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) SRC_ACS_IN[i] = mk(i);
        SRC_WRITE_IN = 4'b0101;
        SRC_REQ_IN   = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            int g;
            g = k % 4;
            step();
            #1;
            total++;
            if (GRANT_OUT !== 4'(1 << g) || DST_REQ_OUT !== 1'b1 || DST_ACS_OUT !== mk(g)) begin
                bad++;
                $display("FAIL rr_grant k=%0d got grant=%b req=%b acs=%h exp grant=%b req=1 acs=%h",
                         k, GRANT_OUT, DST_REQ_OUT, DST_ACS_OUT, 4'(1 << g), mk(g));
            end
            total++;
            if (DST_WRITE_OUT !== ((g % 2) == 0)) begin
                bad++;
                $display("FAIL rr_write k=%0d got=%b", k, DST_WRITE_OUT);
            end
            step();
            step();
            DST_ACK_IN = 1'b1;
            #1;
            total++;
            if (SRC_ACK_OUT !== 4'(1 << g)) begin
                bad++;
                $display("FAIL rr_ack k=%0d got=%b exp=%b", k, SRC_ACK_OUT, 4'(1 << g));
            end
            step();
            DST_ACK_IN = 1'b0;
            if (k == 7) SRC_REQ_IN = '0;
            #1;
            total++;
            if (GRANT_OUT !== 4'b0000 || DST_REQ_OUT !== 1'b0) begin
                bad++;
                $display("FAIL rr_idle k=%0d got grant=%b req=%b exp 0000 0", k, GRANT_OUT, DST_REQ_OUT);
            end
        end
    endtask

    task automatic test_pointer();
        do_reset();
        for (int i = 0; i < 4; i++) SRC_ACS_IN[i] = mk(i);
        SRC_REQ_IN = 4'b0010;
        step();
        step();
        DST_ACK_IN = 1'b1;
        SRC_REQ_IN = 4'b1001;
        step();
        DST_ACK_IN = 1'b0;
        step();
        #1;
        total++;
        if (GRANT_OUT !== 4'b1000 || DST_ACS_OUT !== mk(3)) begin
            bad++;
            $display("FAIL ptr_first got grant=%b acs=%h exp grant=1000 acs=%h",
                     GRANT_OUT, DST_ACS_OUT, mk(3));
        end
        DST_ACK_IN = 1'b1;
        SRC_REQ_IN = 4'b0001;
        step();
        DST_ACK_IN = 1'b0;
        step();
        #1;
        total++;
        if (GRANT_OUT !== 4'b0001 || DST_ACS_OUT !== mk(0)) begin
            bad++;
            $display("FAIL ptr_second got grant=%b acs=%h exp grant=0001 acs=%h",
                     GRANT_OUT, DST_ACS_OUT, mk(0));
        end
        DST_ACK_IN = 1'b1;
        SRC_REQ_IN = 4'b0000;
        step();
        DST_ACK_IN = 1'b0;
    endtask

    task automatic test_drop_req();
        do_reset();
        SRC_ACS_IN[2] = mk(2);
        SRC_REQ_IN    = 4'b0100;
        step();
        SRC_REQ_IN      = 4'b0000;
        SRC_ACS_IN[2]   = mk(9);
        SRC_WRITE_IN[2] = 1'b1;
        step();
        #1;
        total++;
        if (DST_ACS_OUT !== mk(2) || DST_WRITE_OUT !== 1'b0 || DST_REQ_OUT !== 1'b1) begin
            bad++;
            $display("FAIL drop_hold got acs=%h wr=%b req=%b exp acs=%h wr=0 req=1",
                     DST_ACS_OUT, DST_WRITE_OUT, DST_REQ_OUT, mk(2));
        end
        step();
        DST_ACK_IN = 1'b1;
        #1;
        total++;
        if (SRC_ACK_OUT !== 4'b0100) begin
            bad++;
            $display("FAIL drop_ack got=%b exp=0100", SRC_ACK_OUT);
        end
        step();
        DST_ACK_IN = 1'b0;
        #1;
        total++;
        if (GRANT_OUT !== 4'b0000 || DST_REQ_OUT !== 1'b0) begin
            bad++;
            $display("FAIL drop_release got grant=%b req=%b exp 0000 0", GRANT_OUT, DST_REQ_OUT);
        end
    endtask

    task automatic test_idle_ack();
        do_reset();
        step();
        DST_ACK_IN = 1'b1;
        #1;
        total++;
        if (SRC_ACK_OUT !== 4'b0000) begin
            bad++;
            $display("FAIL idle_ack got=%b exp=0000", SRC_ACK_OUT);
        end
        step();
        DST_ACK_IN = 1'b0;
        #1;
        total++;
        if (GRANT_OUT !== 4'b0000 || DST_REQ_OUT !== 1'b0) begin
            bad++;
            $display("FAIL idle_ack_state got grant=%b req=%b exp 0000 0", GRANT_OUT, DST_REQ_OUT);
        end
    endtask

    task automatic test_reset_busy();
        do_reset();
        SRC_ACS_IN[3] = mk(3);
        SRC_WRITE_IN  = 4'b1000;
        SRC_REQ_IN    = 4'b1000;
        step();
        #1;
        total++;
        if (DST_REQ_OUT !== 1'b1 || GRANT_OUT !== 4'b1000 || DST_WRITE_OUT !== 1'b1) begin
            bad++;
            $display("FAIL rstbusy_pre got req=%b grant=%b wr=%b exp 1 1000 1",
                     DST_REQ_OUT, GRANT_OUT, DST_WRITE_OUT);
        end
        RESET_IN = 1'b1;
        step();
        RESET_IN   = 1'b0;
        DST_ACK_IN = 1'b1;
        #1;
        total++;
        if ({DST_REQ_OUT, DST_WRITE_OUT, GRANT_OUT, SRC_ACK_OUT} !== 10'b0 || DST_ACS_OUT !== '0) begin
            bad++;
            $display("FAIL rstbusy_post got req=%b wr=%b grant=%b ack=%b acs=%h exp all 0",
                     DST_REQ_OUT, DST_WRITE_OUT, GRANT_OUT, SRC_ACK_OUT, DST_ACS_OUT);
        end
        SRC_REQ_IN = '0;
        DST_ACK_IN = 1'b0;
        step();
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 1; i < 4; i++) SRC_ACS_IN[i] = mk(i);
        SRC_ACS_IN[0] = mk(10);
        SRC_REQ_IN    = 4'b1111;
        SRC_LOCK_IN   = 4'b0001;
        step();
`ifdef SDRAM_ARB_LOCK_EN
        for (int a = 0; a < 4; a++) begin
            #1;
            total++;
            if (GRANT_OUT !== 4'b0001 || DST_REQ_OUT !== 1'b1 || DST_ACS_OUT !== mk(10 + a)) begin
                bad++;
                $display("FAIL lock_access a=%0d got grant=%b req=%b acs=%h exp grant=0001 req=1 acs=%h",
                         a, GRANT_OUT, DST_REQ_OUT, DST_ACS_OUT, mk(10 + a));
            end
            step();
            step();
            DST_ACK_IN    = 1'b1;
            SRC_ACS_IN[0] = mk(11 + a);
            #1;
            total++;
            if (SRC_ACK_OUT !== 4'b0001) begin
                bad++;
                $display("FAIL lock_ack a=%0d got=%b exp=0001", a, SRC_ACK_OUT);
            end
            step();
            DST_ACK_IN = 1'b0;
        end
`else
        #1;
        total++;
        if (GRANT_OUT !== 4'b0001 || DST_ACS_OUT !== mk(10)) begin
            bad++;
            $display("FAIL nolock_first got grant=%b acs=%h exp grant=0001 acs=%h",
                     GRANT_OUT, DST_ACS_OUT, mk(10));
        end
        step();
        step();
        DST_ACK_IN = 1'b1;
        #1;
        total++;
        if (SRC_ACK_OUT !== 4'b0001) begin
            bad++;
            $display("FAIL nolock_ack got=%b exp=0001", SRC_ACK_OUT);
        end
        step();
        DST_ACK_IN = 1'b0;
`endif
        #1;
        total++;
        if (GRANT_OUT !== 4'b0000 || DST_REQ_OUT !== 1'b0) begin
            bad++;
            $display("FAIL lock_release got grant=%b req=%b exp 0000 0", GRANT_OUT, DST_REQ_OUT);
        end
        SRC_LOCK_IN = 4'b0000;
        step();
        #1;
        total++;
        if (GRANT_OUT !== 4'b0010 || DST_ACS_OUT !== mk(1)) begin
            bad++;
            $display("FAIL lock_next got grant=%b acs=%h exp grant=0010 acs=%h",
                     GRANT_OUT, DST_ACS_OUT, mk(1));
        end
        SRC_REQ_IN = '0;
        step();
        step();
        DST_ACK_IN = 1'b1;
        step();
        DST_ACK_IN = 1'b0;
    endtask

    initial begin
        clear_inputs();
        RESET_IN = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_pointer();
        test_drop_req();
        test_idle_ack();
        test_reset_busy();
        test_lock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
